// File: rtl/dp_ram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_port_arb
// Description : Two-master round-robin arbiter in front of a single-port RAM.
//               The RAM has one cycle of read latency. A response valid goes
//               back to the granted master one cycle after each grant.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_port_arb #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,

    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam logic c_M0 = 1'b0;
    localparam logic c_M1 = 1'b1;

    // last_q holds the ID of the most recently granted master.
    logic last_q, last_d;
    logic rvalid_q, rvalid_d;
    logic rid_q, rid_d;
    logic w_gnt0, w_gnt1;

    // On contention the master that was not served last wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (m0_req_i && m1_req_i) begin
            w_gnt0 = (last_q == c_M1);
            w_gnt1 = (last_q == c_M0);
        end else begin
            w_gnt0 = m0_req_i;
            w_gnt1 = m1_req_i;
        end
    end

    always_comb begin
        last_d   = last_q;
        rvalid_d = w_gnt0 | w_gnt1;
        rid_d    = rid_q;
        if (w_gnt0) begin
            last_d = c_M0;
            rid_d  = c_M0;
        end else if (w_gnt1) begin
            last_d = c_M1;
            rid_d  = c_M1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q   <= c_M1;
            rvalid_q <= 1'b0;
            rid_q    <= c_M0;
        end else begin
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
        end
    end

    // The RAM port is idle-zero so nothing leaks from an ungranted master.
    always_comb begin
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        if (w_gnt0) begin
            ram_addr_o  = m0_addr_i;
            ram_wdata_o = m0_wdata_i;
            ram_we_o    = m0_we_i;
            ram_be_o    = m0_be_i;
        end else if (w_gnt1) begin
            ram_addr_o  = m1_addr_i;
            ram_wdata_o = m1_wdata_i;
            ram_we_o    = m1_we_i;
            ram_be_o    = m1_be_i;
        end
    end

    assign m0_gnt_o    = w_gnt0;
    assign m1_gnt_o    = w_gnt1;
    assign ram_en_o    = w_gnt0 | w_gnt1;

    assign m0_rvalid_o = rvalid_q & (rid_q == c_M0);
    assign m1_rvalid_o = rvalid_q & (rid_q == c_M1);
    assign m0_rdata_o  = ram_rdata_i;
    assign m1_rdata_o  = ram_rdata_i;

endmodule
`default_nettype wire

// File: doc/dp_ram_port_arb.md
DP_RAM_PORT_ARB -- requirements
Module: dp_ram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, which sets the word-address width of masters and RAM port.
REQ-002 SHALL have a single clock, clk: input, 1 bit, all state updates on its rising edge.
REQ-003 SHALL have reset rst_n: input, 1 bit, synchronous, active-low.
REQ-004 SHALL have m0_req_i: input, 1 bit, master 0 access request.
REQ-005 SHALL have m0_gnt_o: output, 1 bit, master 0 request accepted this cycle.
REQ-006 SHALL have m0_addr_i: input, ADDR_WIDTH bits, master 0 word address.
REQ-007 SHALL have m0_we_i: input, 1 bit, master 0 write enable (1 = write).
REQ-008 SHALL have m0_be_i: input, 4 bits, master 0 byte enables.
REQ-009 SHALL have m0_wdata_i: input, 32 bits, master 0 write data.
REQ-010 SHALL have m0_rvalid_o: output, 1 bit, master 0 response valid.
REQ-011 SHALL have m0_rdata_o: output, 32 bits, master 0 read data.
REQ-012 SHALL have m1_req_i, m1_gnt_o, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i, m1_rvalid_o and m1_rdata_o, with the same directions, widths and meanings as the m0 ports, for master 1.
REQ-013 SHALL have ram_en_o: output, 1 bit, RAM port enable.
REQ-014 SHALL have ram_addr_o: output, ADDR_WIDTH bits, RAM address.
REQ-015 SHALL have ram_wdata_o: output, 32 bits, RAM write data.
REQ-016 SHALL have ram_we_o: output, 1 bit, RAM write enable.
REQ-017 SHALL have ram_be_o: output, 4 bits, RAM byte enables.
REQ-018 SHALL have ram_rdata_i: input, 32 bits, RAM read data, valid one cycle after ram_en_o.

Function
REQ-019 SHALL make grant combinational in the same cycle as the request; at most one of m0_gnt_o and m1_gnt_o is high in any cycle.
REQ-020 SHALL assert the grant of a lone requester in the cycle it requests.
REQ-021 SHALL, when both masters request, grant the master that was not last granted (round-robin); the last-granted register last_q updates only on a cycle with a grant.
REQ-022 SHALL drive ram_en_o = m0_gnt_o | m1_gnt_o.
REQ-023 SHALL drive ram_addr_o, ram_wdata_o, ram_we_o and ram_be_o from the granted master.
REQ-024 SHALL drive ram_we_o, ram_be_o and ram_wdata_o to 0 when no master is granted.
REQ-025 SHALL drive ram_addr_o to 0 when no master is granted.
REQ-026 SHALL register the granted master ID and a valid flag; in the cycle after a grant, exactly that master's rvalid_o is 1, for both reads and writes.
REQ-027 SHALL drive both m0_rdata_o and m1_rdata_o from ram_rdata_i; the data is meaningful only when the corresponding rvalid_o is 1.
REQ-028 SHALL sustain back-to-back grants, giving one access per cycle.
REQ-029 SHALL, when both masters request continuously, alternate grants m0, m1, m0, ...
REQ-030 SHALL allow a new grant in the same cycle as the rvalid of the previous access; the two do not interfere.
REQ-031 SHALL grant no master when neither master requests.
REQ-032 SHALL keep last_q unchanged on a cycle with no grant.
REQ-033 SHALL let a master that drops req without a grant lose nothing, with no state change.
REQ-034 SHALL let a requesting master keep req high and hold its address, we, be and wdata stable until granted.

Reset
REQ-035 SHALL, while rst_n = 0 at a clk edge, clear the rvalid flag and set last_q = master 1, so master 0 wins the first contention.
REQ-036 SHALL hold m0_rvalid_o = m1_rvalid_o = 0 for the cycle after any reset edge.
REQ-037 SHALL discard any response pending at reset with no rvalid issued; grants remain combinational during reset but take no effect.
REQ-038 SHALL resume normal arbitration on the first edge with rst_n = 1.

Verification
REQ-039 SHALL cover a lone write then read: m0 writes addr 0x05, we=1, be=0xF, wdata 0xDEADBEEF, then reads 0x05 -> m0_gnt_o high in each request cycle, m0_rvalid_o next cycle, read returns 0xDEADBEEF, and m1_rvalid_o stays 0.
REQ-040 SHALL cover contention after reset: both masters request in the first cycle after reset -> m0 granted; next cycle both request -> m1 granted; ram_addr_o follows the granted master.
REQ-041 SHALL cover continuous contention: both masters request for 6 cycles -> grants m0, m1, m0, m1, m0, m1; rvalids follow one cycle later in the same order.
REQ-042 SHALL cover a byte write: m1 writes be=0x2, wdata 0x0000AB00 to a word holding 0x11223344 -> a subsequent read returns 0x1122AB44.
REQ-043 SHALL cover reset mid-operation: m0 granted on a read, rst_n low on the next edge -> no rvalid on either master; after release, the first contention grants m0.
REQ-044 SHALL cover idle: no requests for 10 cycles -> ram_en_o = 0, no rvalid, and last_q unchanged, checked by the next contention granting the expected master.
